// File: rtl/pmc_shift_if.sv
// Bundle between the PMC register file / matrix pads and the serial shift engine.
// start is accepted only on a cycle with busy=0 and abort=0; done pulses once per
// completed transfer, din_o is valid in that cycle and held until the next done.
interface pmc_shift_if #(
    parameter int NUM_CH = 16,
    parameter int WORD_W = 32,
    parameter int CNT_W  = $clog2(WORD_W) + 1,
    parameter int DIV_W  = 8
);
    logic                     start;
    logic                     abort;
    logic [CNT_W-1:0]         bit_count;
    logic [DIV_W-1:0]         clk_div;
    logic                     msb_first;
    logic [NUM_CH*WORD_W-1:0] dout_i;
    logic [NUM_CH*WORD_W-1:0] din_o;
    logic                     busy;
    logic                     done;
    logic                     sh_clk_o;
    logic [NUM_CH-1:0]        sh_data_o;
    logic [NUM_CH-1:0]        sh_data_i;
    logic [2:0]               state_dbg;

    modport master (
        output start, abort, bit_count, clk_div, msb_first, dout_i, sh_data_i,
        input  din_o, busy, done, sh_clk_o, sh_data_o, state_dbg
    );

    modport slave (
        input  start, abort, bit_count, clk_div, msb_first, dout_i, sh_data_i,
        output din_o, busy, done, sh_clk_o, sh_data_o, state_dbg
    );
endinterface

// File: rtl/pmc_shift_engine.sv
// Serial shift engine: shifts NUM_CH words out over parallel lines with a generated,
// divided shift clock and captures the matrix response on the same clock.
module pmc_shift_engine #(
    parameter int NUM_CH = 16,
    parameter int WORD_W = 32,
    parameter int CNT_W  = $clog2(WORD_W) + 1,
    parameter int DIV_W  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    pmc_shift_if.slave bus
);
    localparam int IDX_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] WORD_N  = CNT_W'(WORD_W);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_HIGH  = 3'd2,
        S_LOW   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                   state;
    logic [DIV_W-1:0]         phase;
    logic [DIV_W-1:0]         div_q;
    logic                     msb_q;
    logic [CNT_W-1:0]         bits_left;
    logic [IDX_W-1:0]         bit_idx;
    logic [WORD_W-1:0]        word_q [NUM_CH];
    logic [WORD_W-1:0]        cap_q  [NUM_CH];
    logic [WORD_W-1:0]        dout_w [NUM_CH];
    logic [CNT_W-1:0]         n_eff;
    logic [IDX_W-1:0]         first_idx;
    logic [IDX_W-1:0]         next_idx;
    logic                     busy_q;
    logic                     done_q;
    logic                     sh_clk_q;
    logic [NUM_CH-1:0]        sh_data_q;
    logic [NUM_CH*WORD_W-1:0] din_q;

    // bit_idx always names the bit currently on the line; it walks down for MSB-first.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            dout_w[c] = bus.dout_i[c*WORD_W +: WORD_W];
        end
        n_eff     = (bus.bit_count == '0 || bus.bit_count > WORD_N) ? WORD_N : bus.bit_count;
        first_idx = bus.msb_first ? IDX_W'(n_eff - CNT_ONE) : '0;
        next_idx  = msb_q ? (bit_idx - IDX_ONE) : (bit_idx + IDX_ONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            phase     <= '0;
            div_q     <= '0;
            msb_q     <= 1'b0;
            bits_left <= '0;
            bit_idx   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sh_clk_q  <= 1'b0;
            sh_data_q <= '0;
            din_q     <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                word_q[c] <= '0;
                cap_q[c]  <= '0;
            end
        end else if (state != S_IDLE && bus.abort) begin
            // sh_data_o and din_o deliberately keep their values on abort
            state    <= S_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            sh_clk_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state     <= S_SETUP;
                        busy_q    <= 1'b1;
                        phase     <= bus.clk_div;
                        div_q     <= bus.clk_div;
                        msb_q     <= bus.msb_first;
                        bits_left <= n_eff;
                        bit_idx   <= first_idx;
                        for (int c = 0; c < NUM_CH; c++) begin
                            word_q[c]    <= dout_w[c];
                            cap_q[c]     <= '0;
                            sh_data_q[c] <= dout_w[c][first_idx];
                        end
                    end
                end
                S_SETUP: begin
                    if (phase == '0) begin
                        state    <= S_HIGH;
                        phase    <= div_q;
                        sh_clk_q <= 1'b1;
                    end else begin
                        phase <= phase - DIV_ONE;
                    end
                end
                S_HIGH: begin
                    if (phase == '0) begin
                        state     <= S_LOW;
                        phase     <= div_q;
                        sh_clk_q  <= 1'b0;
                        bits_left <= bits_left - CNT_ONE;
                        for (int c = 0; c < NUM_CH; c++) begin
                            if (msb_q) begin
                                cap_q[c] <= {cap_q[c][WORD_W-2:0], bus.sh_data_i[c]};
                            end else begin
                                cap_q[c][bit_idx] <= bus.sh_data_i[c];
                            end
                        end
                        // After the final bit the line simply holds its value
                        if (bits_left != CNT_ONE) begin
                            bit_idx <= next_idx;
                            for (int c = 0; c < NUM_CH; c++) begin
                                sh_data_q[c] <= word_q[c][next_idx];
                            end
                        end
                    end else begin
                        phase <= phase - DIV_ONE;
                    end
                end
                S_LOW: begin
                    if (phase == '0) begin
                        if (bits_left != '0) begin
                            state    <= S_HIGH;
                            phase    <= div_q;
                            sh_clk_q <= 1'b1;
                        end else begin
                            state  <= S_DONE;
                            done_q <= 1'b1;
                            for (int c = 0; c < NUM_CH; c++) begin
                                din_q[c*WORD_W +: WORD_W] <= cap_q[c];
                            end
                        end
                    end else begin
                        phase <= phase - DIV_ONE;
                    end
                end
                S_DONE: begin
                    state  <= S_IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state    <= S_IDLE;
                    busy_q   <= 1'b0;
                    sh_clk_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.sh_clk_o  = sh_clk_q;
    assign bus.sh_data_o = sh_data_q;
    assign bus.din_o     = din_q;
    assign bus.state_dbg = state;
endmodule
